// File: rtl/systolic_pe_if.sv
// rtl/systolic_pe_if.sv - operand, forwarding and result bundle of one systolic PE
interface systolic_pe_if #(
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
);
  logic             is;
  logic             start;
  logic [CNT_W-1:0] k_len;
  logic             w_rv;
  logic             w_re;
  logic [DW-1:0]    w_din;
  logic             n_rv;
  logic             n_re;
  logic [DW-1:0]    n_din;
  logic             e_ff;
  logic             e_we;
  logic [DW-1:0]    e_dout;
  logic             s_ff;
  logic             s_we;
  logic [DW-1:0]    s_dout;
  logic             res_valid;
  logic             res_ack;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  modport slave (
    input  is, start, k_len, w_rv, w_din, n_rv, n_din, e_ff, s_ff, res_ack,
    output w_re, n_re, e_we, e_dout, s_we, s_dout, res_valid, res_data, busy
  );

  modport master (
    output is, start, k_len, w_rv, w_din, n_rv, n_din, e_ff, s_ff, res_ack,
    input  w_re, n_re, e_we, e_dout, s_we, s_dout, res_valid, res_data, busy
  );
endinterface

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - lock-step west/north MAC PE with 1-entry east/south forwarding registers
module systolic_pe #(
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  systolic_pe_if.slave  pe
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [DW-1:0]    e_dout_q, e_dout_d;
  logic [DW-1:0]    s_dout_q, s_dout_d;
  logic             e_ov_q, e_ov_d;
  logic             s_ov_q, s_ov_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic             e_we, s_we, e_free, s_free, fire, last;
  logic signed [ACC_W-1:0] w_ext, n_ext;
  logic [ACC_W-1:0] prod;

  assign e_we   = e_ov_q & ~pe.e_ff & ~pe.is;
  assign s_we   = s_ov_q & ~pe.s_ff & ~pe.is;
  assign e_free = ~e_ov_q | e_we;
  assign s_free = ~s_ov_q | s_we;
  // Both lanes pop together only when both forwarding registers can take a new operand.
  assign fire   = (state_q == RUN) & pe.w_rv & pe.n_rv & ~pe.is & e_free & s_free;
  assign last   = (cnt_q == len_q - CNT_W'(1));

  // Product taken at accumulator width so it wraps with the accumulator.
  assign w_ext  = ACC_W'($signed(pe.w_din));
  assign n_ext  = ACC_W'($signed(pe.n_din));
  assign prod   = w_ext * n_ext;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    e_dout_d = e_dout_q;
    s_dout_d = s_dout_q;
    e_ov_d   = e_ov_q;
    s_ov_d   = s_ov_q;
    if (e_we) e_ov_d = 1'b0;
    if (s_we) s_ov_d = 1'b0;
    if (fire) begin
      e_dout_d = pe.w_din;
      s_dout_d = pe.n_din;
      e_ov_d   = 1'b1;
      s_ov_d   = 1'b1;
      acc_d    = acc_q + prod;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    if (!pe.is) begin
      case (state_q)
        IDLE: if (pe.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          len_d   = pe.k_len;
          state_d = (pe.k_len == '0) ? DONE : RUN;
        end
        RUN:  if (fire && last) state_d = DONE;
        DONE: if (pe.res_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      e_dout_q    <= '0;
      s_dout_q    <= '0;
      e_ov_q      <= 1'b0;
      s_ov_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      e_dout_q    <= e_dout_d;
      s_dout_q    <= s_dout_d;
      e_ov_q      <= e_ov_d;
      s_ov_q      <= s_ov_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign pe.w_re      = fire;
  assign pe.n_re      = fire;
  assign pe.e_we      = e_we;
  assign pe.s_we      = s_we;
  assign pe.e_dout    = e_dout_q;
  assign pe.s_dout    = s_dout_q;
  assign pe.res_valid = res_valid_q;
  assign pe.res_data  = acc_q;
  assign pe.busy      = busy_q;
endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - scoreboard bench: FIFO/sink models around systolic_pe, dot-product reference
module tb_systolic_pe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_pe_if #(.DW(16), .ACC_W(32), .CNT_W(8)) pe ();
  systolic_pe #(.DW(16), .ACC_W(32), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .pe(pe.slave));

  int n_cmp = 0, n_bad = 0;
  logic [15:0] dw[$], dn[$];
  logic [15:0] src_w[$], src_n[$], fifo_w[$], fifo_n[$];
  logic [15:0] exp_e[$], exp_s[$];
  logic [31:0] exp_res[$];
  int  w_pops = 0, n_pops = 0, e_push = 0, base_w = 0, base_n = 0;
  bit  rand_en = 0, force_eff = 0, force_is = 0, starve_n = 0, spurious = 0, start_req = 0;
  logic [7:0] k_req = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream FIFOs (depth 4) and downstream sinks; all inputs change just after the rising edge.
  initial begin : driver
    bit wpop, npop;
    forever begin
      @(negedge clk);
      wpop = pe.w_re;
      npop = pe.n_re;
      @(posedge clk);
      #1;
      pe.start = 1'b0;
      if (!rst_n) begin
        fifo_w.delete(); fifo_n.delete(); src_w.delete(); src_n.delete();
        pe.w_rv = 1'b0; pe.n_rv = 1'b0; pe.is = 1'b0;
        continue;
      end
      if (wpop && fifo_w.size() > 0) void'(fifo_w.pop_front());
      if (npop && fifo_n.size() > 0) void'(fifo_n.pop_front());
      if (src_w.size() > 0 && fifo_w.size() < 4 && (!rand_en || $urandom_range(3) != 0))
        fifo_w.push_back(src_w.pop_front());
      if (src_n.size() > 0 && fifo_n.size() < 4 && (!rand_en || $urandom_range(3) != 0))
        fifo_n.push_back(src_n.pop_front());
      pe.w_rv    = fifo_w.size() > 0;
      pe.w_din   = (fifo_w.size() > 0) ? fifo_w[0] : 16'($urandom);
      pe.n_rv    = (fifo_n.size() > 0) && !starve_n;
      pe.n_din   = (fifo_n.size() > 0) ? fifo_n[0] : 16'($urandom);
      pe.e_ff    = force_eff || (rand_en && $urandom_range(3) == 0);
      pe.s_ff    = rand_en && $urandom_range(3) == 0;
      pe.res_ack = rand_en ? 1'($urandom_range(1)) : 1'b1;
      pe.is      = force_is || (rand_en && $urandom_range(7) == 0);
      if (spurious) begin
        pe.start = 1'b1; pe.k_len = 8'd7; spurious = 0;
      end else if (start_req && !pe.busy) begin
        pe.start = 1'b1; pe.is = 1'b0; pe.k_len = k_req; start_req = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT pushes or hands over a result.
  initial begin : monitor
    int e_occ;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_e.delete(); exp_s.delete(); exp_res.delete();
        w_pops = 0; n_pops = 0; e_push = 0;
        continue;
      end
      e_occ = w_pops - e_push;
      if (pe.w_re || pe.n_re) begin
        check("lockstep_pop", {pe.w_re, pe.n_re}, 2'b11);
        check("pop_needs_both_rv", pe.w_rv & pe.n_rv, 1);
      end
      if (pe.is) check("inhibit_no_handshake", {pe.w_re, pe.n_re, pe.e_we, pe.s_we}, 0);
      if (pe.e_ff) check("e_ff_blocks_push", pe.e_we, 0);
      if (pe.w_re) check("east_single_entry", (e_occ == 0) || pe.e_we, 1);
      if (pe.e_we) begin
        if (exp_e.size() == 0) check("east_unexpected_push", 1, 0);
        else check("east_data", pe.e_dout, exp_e.pop_front());
        e_push++;
      end
      if (pe.s_we) begin
        if (exp_s.size() == 0) check("south_unexpected_push", 1, 0);
        else check("south_data", pe.s_dout, exp_s.pop_front());
      end
      if (pe.w_re) w_pops++;
      if (pe.n_re) n_pops++;
      if (pe.res_valid && pe.res_ack && !pe.is) begin
        if (exp_res.size() == 0) check("unexpected_result", 1, 0);
        else check("res_data", pe.res_data, exp_res.pop_front());
      end
    end
  end

  task automatic add_pair(input logic [15:0] w, input logic [15:0] n);
    dw.push_back(w);
    dn.push_back(n);
  endtask

  task automatic run(input int k, input bit wait_done);
    longint s = 0;
    int t = 0;
    for (int i = 0; i < k; i++) begin
      s += longint'($signed(dw[i])) * longint'($signed(dn[i]));
      src_w.push_back(dw[i]); exp_e.push_back(dw[i]);
      src_n.push_back(dn[i]); exp_s.push_back(dn[i]);
    end
    exp_res.push_back(s[31:0]);
    base_w = w_pops; base_n = n_pops;
    k_req = 8'(k);
    start_req = 1;
    while (start_req && t < 200) begin @(negedge clk); t++; end
    check("start_accepted", start_req, 0);
    if (wait_done) finish_run(k);
  endtask

  task automatic finish_run(input int k);
    int t = 0;
    while ((exp_res.size() > 0 || exp_e.size() > 0 || exp_s.size() > 0 || pe.busy) && t < 3000) begin
      @(negedge clk); t++;
    end
    #1;
    check("run_completes", t < 3000, 1);
    check("west_pop_count", w_pops - base_w, k);
    check("north_pop_count", n_pops - base_n, k);
    dw.delete(); dn.delete();
  endtask

  task automatic wait_pops(input int n);
    int t = 0;
    while (w_pops - base_w < n && t < 500) begin @(negedge clk); t++; end
    check("pops_reached", t < 500, 1);
  endtask

  task automatic fill_random(input int k);
    dw.delete(); dn.delete();
    for (int i = 0; i < k; i++) add_pair(16'($urandom), 16'($urandom));
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int pb;
    rst_n = 1'b0;
    pe.is = 0; pe.start = 0; pe.k_len = 0; pe.w_rv = 0; pe.w_din = 0;
    pe.n_rv = 0; pe.n_din = 0; pe.e_ff = 0; pe.s_ff = 0; pe.res_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", pe.busy, 0);
    check("rst_res_valid", pe.res_valid, 0);
    check("rst_res_data", pe.res_data, 0);
    check("rst_e_dout", pe.e_dout, 0);
    check("rst_s_dout", pe.s_dout, 0);
    check("rst_pushes", {pe.e_we, pe.s_we, pe.w_re}, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);

    add_pair(1, 5); add_pair(2, 6); add_pair(3, 7); add_pair(4, 8);
    run(4, 1);

    add_pair(16'hFFFF, 16'h0002); add_pair(16'h8000, 16'h0001);
    run(2, 1);

    run(0, 0);
    @(negedge clk);
    check("k0_done_next_cycle", pe.res_valid, 1);
    check("k0_res_zero", pe.res_data, 0);
    finish_run(0);

    fill_random(6);
    run(6, 0);
    wait_pops(1);
    spurious = 1;
    wait_pops(2);
    force_eff = 1;
    @(posedge clk); #2;
    pb = w_pops;
    repeat (5) begin @(negedge clk); check("eff_hold_no_push", pe.e_we, 0); end
    #1 check("eff_hold_pops_le1", (w_pops - pb) <= 1, 1);
    force_eff = 0;
    finish_run(6);

    fill_random(6);
    run(6, 0);
    wait_pops(1);
    starve_n = 1;
    @(posedge clk); #2;
    pb = w_pops;
    repeat (3) begin @(negedge clk); check("starve_no_west_pop", pe.w_re, 0); end
    #1 check("starve_west_pops", w_pops - pb, 0);
    starve_n = 0;
    finish_run(6);

    fill_random(6);
    run(6, 0);
    wait_pops(2);
    force_is = 1;
    @(posedge clk); #2;
    pb = w_pops;
    repeat (4) begin
      @(negedge clk);
      check("is_no_pop", pe.w_re | pe.n_re, 0);
      check("is_no_push", pe.e_we | pe.s_we, 0);
      check("is_busy_held", pe.busy, 1);
      check("is_no_result", pe.res_valid, 0);
    end
    #1 check("is_pops_frozen", w_pops - pb, 0);
    force_is = 0;
    finish_run(6);

    fill_random(4);
    run(4, 0);
    wait_pops(2);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", pe.busy, 0);
    check("midrst_res_valid", pe.res_valid, 0);
    check("midrst_res_data", pe.res_data, 0);
    check("midrst_douts", {pe.e_dout, pe.s_dout}, 0);
    check("midrst_handshakes", {pe.e_we, pe.s_we, pe.w_re, pe.n_re}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    dw.delete(); dn.delete();
    add_pair(3, 4);
    run(1, 1);

    rand_en = 1;
    repeat (10) begin
      int k;
      k = $urandom_range(1, 12);
      fill_random(k);
      run(k, 1);
    end
    rand_en = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
- Processing element of the systolic array; sits directly downstream of the 4-deep 16-bit per-lane FIFOs.
- Pops one operand from its west FIFO and one from its north FIFO in lock-step, and multiply-accumulates them.
- Forwards the west operand east and the north operand south, each through a 1-entry output register, into the neighbouring PEs' FIFOs.
- After K_LEN operand pairs, presents the accumulated dot product on a valid/ack result port.

Parameters:
- DW, 16: operand width; equals FIFO data width.
- ACC_W, 32: accumulator width, ≥ 2*DW.
- CNT_W, 8: width of the length counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- is  input  1  global inhibit; freezes all pops, pushes and state updates
- start  input  1  1-cycle pulse; clears accumulator and begins a run (honoured only in IDLE)
- k_len  input  CNT_W  number of operand pairs in the run; sampled on start
- w_rv  input  1  west FIFO not empty
- w_re  output  1  west FIFO pop
- w_din  input  DW  west FIFO head data
- n_rv  input  1  north FIFO not empty
- n_re  output  1  north FIFO pop
- n_din  input  DW  north FIFO head data
- e_ff  input  1  east FIFO full
- e_we  output  1  east FIFO push
- e_dout  output  DW  east push data
- s_ff  input  1  south FIFO full
- s_we  output  1  south FIFO push
- s_dout  output  DW  south push data
- res_valid  output  1  result available
- res_ack  input  1  result consumed
- res_data  output  ACC_W  accumulated result
- busy  output  1  state != IDLE

Behaviour:
- Reset values: state IDLE; acc, cnt, len_q, e_dout, s_dout = 0; e_ov, s_ov = 0; res_valid = 0; busy = 0.
- States: IDLE=0, RUN=1, DONE=2. Encoding is fixed.
- Output push (combinational):
  - e_we = e_ov & ~e_ff & ~is; s_we = s_ov & ~s_ff & ~is.
  - e_dout and s_dout are the output registers.
- e_free = ~e_ov | e_we; s_free = ~s_ov | s_we.
- fire = (state==RUN) & w_rv & n_rv & ~is & e_free & s_free.
- w_re = n_re = fire (combinational). The two lanes are never popped independently.
- On fire:
  - e_dout <= w_din, e_ov <= 1; s_dout <= n_din, s_ov <= 1.
  - acc <= acc + sext(w_din) * sext(n_din), signed, wraps modulo 2^ACC_W.
  - cnt <= cnt + 1.
- Output register release: if e_we and not fire, e_ov <= 0. Same rule for s_ov with s_we.
- Forward latency: operand popped at cycle t is pushed downstream at t+1 at the earliest, later only while ff holds it.
- Output registers drain in every state, including IDLE and DONE.
- IDLE -> RUN on start & ~is: acc <= 0, cnt <= 0, len_q <= k_len.
  - If k_len == 0, go IDLE -> DONE directly with acc = 0.
- RUN -> DONE on a fire with cnt == len_q-1. This final product is included in res_data.
- DONE: res_valid = 1, res_data = acc. On res_ack & ~is, go to IDLE and drop res_valid the next cycle.
- start outside IDLE is ignored. res_ack outside DONE is ignored.
- is = 1 holds state, acc, cnt and output registers, and forces w_re, n_re, e_we, s_we to 0.
- Only one side ready (w_rv & ~n_rv, or the reverse): no pop on either side, no state change.
- rst_n asserted mid-run returns all state to reset values immediately. Held output data is lost; no partial push is emitted.

Test Plan:
- Basic dot product: start with k_len=4; west 1,2,3,4; north 5,6,7,8; FIFOs always ready, no ff.
  - Exactly 4 pops on each side.
  - res_valid high with res_data=70.
  - East sees 1,2,3,4 and south sees 5,6,7,8, each pushed one cycle after its pop.
- Signed operands: k_len=2; west 0xFFFF, 0x8000; north 0x0002, 0x0001 -> res_data = 0xFFFF7FFE (-2 + -32768).
- Backpressure: hold e_ff=1 for 5 cycles mid-run.
  - At most one held east item; no pops while e_ov is stuck; e_we=0 throughout.
  - After release, run completes with the correct sum and no data loss or duplication.
- Asymmetric starvation: hold n_rv=0 while w_rv=1 for 3 cycles -> w_re stays 0 and the west FIFO occupancy is unchanged.
- Inhibit and handshake:
  - is=1 for 4 cycles during RUN freezes every output and counter.
  - k_len=0 -> DONE on the next cycle with res_data=0.
  - res_ack returns to IDLE.
  - start during RUN is ignored.
- Reset mid-run: assert rst_n low after 2 of 4 pairs -> all outputs return to reset values; a following run of k_len=1 on 3*4 gives res_data=12.
